// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-class LCD write controller:
// FSM states, power-on init ROM and command classification helpers.
package lcd_pkg;

    typedef enum logic [2:0] {
        PWRON_WAIT,
        INIT_LOAD,
        IDLE,
        SETUP,
        EN_HIGH,
        HOLD,
        EXEC_WAIT
    } lcd_state_e;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;

    localparam int INIT_LEN = 4;

    typedef logic [2:0] init_idx_t;

    function automatic logic [7:0] init_rom(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0: cmd = CMD_FUNC_SET;
            2'd1: cmd = CMD_DISP_ON;
            2'd2: cmd = CMD_CLEAR;
            2'd3: cmd = CMD_ENTRY;
        endcase
        return cmd;
    endfunction

    // Clear display (0x01) and return home (0x02/0x03) are the slow instructions.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data[7:2] == 6'd0) && (data != 8'd0);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_write_ctrl_if.sv
// Request handshake and LCD pin bundle between the processor-side
// store decoder and the LCD write controller.
interface lcd_write_ctrl_if;

    logic       i_req_valid;
    logic       i_req_rs;
    logic [7:0] i_req_data;
    logic       o_req_ready;
    logic       o_init_done;
    logic [7:0] o_lcd_data;
    logic       o_lcd_rs;
    logic       o_lcd_rw;
    logic       o_lcd_en;
    logic       o_lcd_on;

    modport master (
        output i_req_valid, i_req_rs, i_req_data,
        input  o_req_ready, o_init_done, o_lcd_data, o_lcd_rs,
               o_lcd_rw, o_lcd_en, o_lcd_on
    );

    modport slave (
        input  i_req_valid, i_req_rs, i_req_data,
        output o_req_ready, o_init_done, o_lcd_data, o_lcd_rs,
               o_lcd_rw, o_lcd_en, o_lcd_on
    );

endinterface

// File: rtl/lcd_timer.sv
// Loadable down-counter shared by every timed state of the LCD controller;
// o_zero flags the last cycle of the current interval.
module lcd_timer #(
    parameter int               CNT_W   = 20,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_zero
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= RST_VAL;
        end else if (i_load) begin
            count_q <= i_load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign o_zero = (count_q == '0);

endmodule

// File: rtl/lcd_write_ctrl.sv
// HD44780-class LCD write controller: power-on init sequence, then
// byte writes from the request handshake with RS/EN/DB bus timing.
module lcd_write_ctrl
    import lcd_pkg::*;
#(
    parameter int T_PWRON_CYC     = 750_000,
    parameter int T_SETUP_CYC     = 4,
    parameter int T_EN_CYC        = 25,
    parameter int T_HOLD_CYC      = 4,
    parameter int T_EXEC_CYC      = 2_000,
    parameter int T_EXEC_LONG_CYC = 82_000
) (
    input logic             i_clk,
    input logic             i_rst,
    lcd_write_ctrl_if.slave bus
);

    localparam int T_MAX = max_int(max_int(max_int(T_PWRON_CYC, T_SETUP_CYC),
                                           max_int(T_EN_CYC, T_HOLD_CYC)),
                                   max_int(T_EXEC_CYC, T_EXEC_LONG_CYC));
    localparam int CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    typedef logic [CNT_W-1:0] cnt_t;

    // Timer is loaded with N-1 so each interval lasts exactly N cycles.
    localparam cnt_t PWRON_LD = cnt_t'(T_PWRON_CYC - 1);
    localparam cnt_t SETUP_LD = cnt_t'(T_SETUP_CYC - 1);
    localparam cnt_t EN_LD    = cnt_t'(T_EN_CYC - 1);
    localparam cnt_t HOLD_LD  = cnt_t'(T_HOLD_CYC - 1);
    localparam cnt_t EXEC_LD  = cnt_t'(T_EXEC_CYC - 1);
    localparam cnt_t LONG_LD  = cnt_t'(T_EXEC_LONG_CYC - 1);

    lcd_state_e state_q, state_d;

    logic       tmr_load;
    cnt_t       tmr_val;
    logic       tmr_zero;
    logic       latch_rom;
    logic       latch_req;

    init_idx_t  init_idx_q;
    logic [7:0] data_q;
    logic       rs_q;
    logic       en_q;
    logic       on_q;
    logic       ready_q;
    logic       init_done_q;

    lcd_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (PWRON_LD)
    ) u_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (tmr_load),
        .i_load_val (tmr_val),
        .o_zero     (tmr_zero)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= PWRON_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        latch_rom = 1'b0;
        latch_req = 1'b0;
        case (state_q)
            PWRON_WAIT: begin
                if (tmr_zero) begin
                    state_d = INIT_LOAD;
                end
            end
            INIT_LOAD: begin
                state_d   = SETUP;
                tmr_load  = 1'b1;
                tmr_val   = SETUP_LD;
                latch_rom = 1'b1;
            end
            IDLE: begin
                if (bus.i_req_valid) begin
                    state_d   = SETUP;
                    tmr_load  = 1'b1;
                    tmr_val   = SETUP_LD;
                    latch_req = 1'b1;
                end
            end
            SETUP: begin
                if (tmr_zero) begin
                    state_d  = EN_HIGH;
                    tmr_load = 1'b1;
                    tmr_val  = EN_LD;
                end
            end
            EN_HIGH: begin
                if (tmr_zero) begin
                    state_d  = HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_LD;
                end
            end
            HOLD: begin
                if (tmr_zero) begin
                    state_d  = EXEC_WAIT;
                    tmr_load = 1'b1;
                    tmr_val  = is_long_cmd(rs_q, data_q) ? LONG_LD : EXEC_LD;
                end
            end
            EXEC_WAIT: begin
                if (tmr_zero) begin
                    state_d = (init_idx_q < init_idx_t'(INIT_LEN)) ? INIT_LOAD : IDLE;
                end
            end
            default: begin
                state_d = PWRON_WAIT;
            end
        endcase
    end

    // Pin-facing outputs are registered from the next state so EN never glitches.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            init_idx_q  <= '0;
            data_q      <= '0;
            rs_q        <= 1'b0;
            en_q        <= 1'b0;
            on_q        <= 1'b0;
            ready_q     <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            on_q    <= 1'b1;
            en_q    <= (state_d == EN_HIGH);
            ready_q <= (state_d == IDLE);
            if (state_d == IDLE) begin
                init_done_q <= 1'b1;
            end
            if (latch_rom) begin
                data_q     <= init_rom(init_idx_q[1:0]);
                rs_q       <= 1'b0;
                init_idx_q <= init_idx_q + init_idx_t'(1);
            end else if (latch_req) begin
                data_q <= bus.i_req_data;
                rs_q   <= bus.i_req_rs;
            end
        end
    end

    assign bus.o_req_ready = ready_q;
    assign bus.o_init_done = init_done_q;
    assign bus.o_lcd_data  = data_q;
    assign bus.o_lcd_rs    = rs_q;
    assign bus.o_lcd_rw    = 1'b0;
    assign bus.o_lcd_en    = en_q;
    assign bus.o_lcd_on    = on_q;

endmodule

// File: tb/tb_lcd_write_ctrl.sv
// Scoreboard bench for lcd_write_ctrl with shortened timing parameters:
// expected EN pulses are queued by the stimulus and checked by a monitor.
module tb_lcd_write_ctrl;

    localparam int P_PWRON = 20;
    localparam int P_SETUP = 2;
    localparam int P_EN    = 4;
    localparam int P_HOLD  = 2;
    localparam int P_EXEC  = 10;
    localparam int P_LONG  = 30;

    typedef struct {
        logic [8:0] v;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    lcd_write_ctrl_if bus();

    lcd_write_ctrl #(
        .T_PWRON_CYC     (P_PWRON),
        .T_SETUP_CYC     (P_SETUP),
        .T_EN_CYC        (P_EN),
        .T_HOLD_CYC      (P_HOLD),
        .T_EXEC_CYC      (P_EXEC),
        .T_EXEC_LONG_CYC (P_LONG)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_ge(input string name, input int act, input int lim);
        checks++;
        if (act < lim) begin
            failures++;
            $display("FAIL %s: got %0d required >= %0d (cycle %0d)", name, act, lim, cyc);
        end
    endtask

    task automatic push_exp(input logic [8:0] v, input int c);
        exp_t e;
        e.v   = v;
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic push_init;
        push_exp({1'b0, 8'h38}, 23);
        push_exp({1'b0, 8'h0C}, 42);
        push_exp({1'b0, 8'h01}, 61);
        push_exp({1'b0, 8'h06}, 100);
    endtask

    task automatic wait_cyc(input int n);
        int g = 0;
        while (cyc != n && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (cyc != n) begin
            checks++;
            failures++;
            $display("FAIL wait_cyc: got cycle %0d required %0d", cyc, n);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic rs, input logic [7:0] d, input bit keep_valid,
                        output int acc);
        int g = 0;
        bus.i_req_valid = 1'b1;
        bus.i_req_rs    = rs;
        bus.i_req_data  = d;
        while (!bus.o_req_ready && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (!bus.o_req_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got ready=0 required ready=1 for byte 0x%0h", d);
            bus.i_req_valid = 1'b0;
            acc = -1;
        end else begin
            acc = cyc;
            @(negedge clk);
            if (!keep_valid) bus.i_req_valid = 1'b0;
            push_exp({rs, d}, acc + 3);
        end
    endtask

    task automatic measure_busy(input string name, input int exp);
        int n = 0;
        while (!bus.o_req_ready && n < 2000) begin
            n++;
            @(negedge clk);
        end
        check(name, n, exp);
    endtask

    // Monitor: every EN pulse is matched against the queue and its timing checked.
    initial begin
        logic       en_prev;
        logic [8:0] cur, prev_v, held_v;
        int         hi_cnt, stable_cnt, hold_left;
        bit         hold_ok;
        exp_t       e;
        en_prev = 1'b0; prev_v = '0; held_v = '0;
        hi_cnt = 0; stable_cnt = 0; hold_left = 0; hold_ok = 1'b1;
        forever begin
            @(negedge clk);
            cur = {bus.o_lcd_rs, bus.o_lcd_data};
            if (rst) begin
                en_prev = 1'b0; hi_cnt = 0; stable_cnt = 0; hold_left = 0;
            end else begin
                stable_cnt = (cur == prev_v) ? stable_cnt + 1 : 1;
                if (bus.o_lcd_en && !en_prev) begin
                    check("rw_low", bus.o_lcd_rw, 0);
                    check_ge("setup_cycles", stable_cnt - 1, P_SETUP);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_pulse: got 0x%0h required no pulse (cycle %0d)", cur, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("pulse_byte", cur, e.v);
                        check("pulse_cycle", cyc, e.cyc);
                    end
                    hi_cnt = 1;
                    held_v = cur;
                end else if (bus.o_lcd_en) begin
                    hi_cnt++;
                    if (cur != held_v) hold_ok = 1'b0;
                end else if (en_prev) begin
                    check("en_width", hi_cnt, P_EN);
                    hold_left = P_HOLD;
                end
                if (!bus.o_lcd_en && hold_left > 0) begin
                    if (cur != held_v) hold_ok = 1'b0;
                    hold_left--;
                    if (hold_left == 0) begin
                        check("hold_stable", hold_ok, 1);
                        hold_ok = 1'b1;
                    end
                end
                en_prev = bus.o_lcd_en;
            end
            prev_v = cur;
        end
    end

    initial begin
        repeat (5000) @(posedge clk);
        $display("FAIL watchdog: got no finish required finish within 5000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc_prev, g;
        bus.i_req_valid = 1'b0;
        bus.i_req_rs    = 1'b0;
        bus.i_req_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {bus.o_req_ready, bus.o_init_done, bus.o_lcd_data, bus.o_lcd_rs,
               bus.o_lcd_rw, bus.o_lcd_en, bus.o_lcd_on}, 0);

        // Request pending during the whole init sequence.
        push_init();
        bus.i_req_valid = 1'b1;
        bus.i_req_rs    = 1'b1;
        bus.i_req_data  = 8'h55;
        rst = 1'b0;
        wait_cyc(1);
        check("lcd_on_after_release", bus.o_lcd_on, 1);
        check("ready_during_init", bus.o_req_ready, 0);
        wait_cyc(115);
        check("init_done_cycle115", {bus.o_init_done, bus.o_req_ready}, 2'b00);
        wait_cyc(116);
        check("init_done_cycle116", {bus.o_init_done, bus.o_req_ready}, 2'b11);
        send(1'b1, 8'h55, 1'b0, acc);
        check("first_accept_cycle", acc, 116);
        measure_busy("busy_data_55", 18);

        send(1'b1, 8'h41, 1'b0, acc);
        measure_busy("busy_data_41", 18);
        send(1'b0, 8'h02, 1'b0, acc);
        measure_busy("busy_cmd_home", 38);
        send(1'b1, 8'h01, 1'b0, acc);
        measure_busy("busy_data_01", 18);
        send(1'b0, 8'h80, 1'b0, acc);
        measure_busy("busy_cmd_ddram", 18);

        // Back-to-back with valid held high.
        send(1'b1, 8'h48, 1'b1, acc_prev);
        send(1'b1, 8'h49, 1'b1, acc);
        check("b2b_gap_1", acc - acc_prev, 19);
        acc_prev = acc;
        send(1'b1, 8'h21, 1'b0, acc);
        check("b2b_gap_2", acc - acc_prev, 19);
        measure_busy("busy_b2b_last", 18);

        // Reset while EN is high.
        send(1'b1, 8'h5A, 1'b0, acc);
        g = 0;
        while (!bus.o_lcd_en && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("en_seen_before_reset", bus.o_lcd_en, 1);
        #1 rst = 1'b1;
        @(negedge clk);
        check("reset_mid_en",
              {bus.o_lcd_en, bus.o_lcd_on, bus.o_req_ready, bus.o_init_done}, 0);
        push_init();
        @(negedge clk);
        rst = 1'b0;
        wait_cyc(115);
        check("reinit_cycle115", {bus.o_init_done, bus.o_req_ready}, 2'b00);
        wait_cyc(116);
        check("reinit_cycle116", {bus.o_init_done, bus.o_req_ready}, 2'b11);
        send(1'b1, 8'h30, 1'b0, acc);
        check("reinit_accept_cycle", acc, 116);
        measure_busy("busy_after_reinit", 18);

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
